mul_seq_unit: RTL and testbench

- Iterative shift-add multiplier that executes the multiply operations selected by the instruction decoder: MUL, UMULL and SMULL.
- Sits beside the ALU in the multicycle datapath.
- The control FSM pulses start with the operands and the multiply ALUControl code, stalls while busy, and writes the result on the done pulse.
- Produces the 32-bit MUL result, or the 64-bit {hi,lo} long result, plus N/Z flags.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_seq_unit_if.sv | 28 ++
 rtl/mul_seq_unit.sv | 126 ++++++++++++
 tb/tb_mul_seq_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: multiply op codes and the control state encoding.
// Also used by the main FSM and the instruction decoder.
package mul_pkg;

    localparam logic [2:0] MUL_OP   = 3'b101;
    localparam logic [2:0] UMULL_OP = 3'b110;
    localparam logic [2:0] SMULL_OP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    function automatic logic is_mul_op(input logic [2:0] code);
        return (code == MUL_OP) || (code == UMULL_OP) || (code == SMULL_OP);
    endfunction

endpackage

// File: rtl/mul_seq_unit_if.sv
// Request/result bundle between the multicycle control path and the multiplier.
// The control side is the master; the multiplier is the slave.
interface mul_seq_unit_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;
    logic             long;
    logic [1:0]       MulFlags;

    modport master (
        output start, ALUControl, SrcA, SrcB,
        input  busy, done, ResultLo, ResultHi, long, MulFlags
    );

    modport slave (
        input  start, ALUControl, SrcA, SrcB,
        output busy, done, ResultLo, ResultHi, long, MulFlags
    );

endinterface

// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier for MUL, UMULL and SMULL: one partial product per cycle,
// a sign fix-up cycle for SMULL, then a single-cycle done pulse with registered results.
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    mul_seq_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t state, state_next;

    logic [CW-1:0]      count;
    logic [2:0]         op;
    logic               neg;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] final_prod;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               smull_req;
    logic               accept;
    logic               n_flag;
    logic               z_flag;

    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic               long_q;
    logic [1:0]         flags_q;

    assign accept    = (state == IDLE) && bus.start && is_mul_op(bus.ALUControl);
    assign smull_req = (bus.ALUControl == SMULL_OP);
    assign a_mag     = (smull_req && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    assign b_mag     = (smull_req && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

    // The carry out of the add is shifted into acc_hi, so the sum keeps one extra bit.
    assign sum        = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign product    = {acc_hi, acc_lo};
    assign final_prod = ((op == SMULL_OP) && neg) ? -product : product;

    always_comb begin
        n_flag = 1'b0;
        z_flag = 1'b0;
        if (op == MUL_OP) begin
            n_flag = final_prod[WIDTH-1];
            z_flag = (final_prod[WIDTH-1:0] == '0);
        end else begin
            n_flag = final_prod[2*WIDTH-1];
            z_flag = (final_prod == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (count == LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are only written on the FIX edge, so an aborted operation never leaks out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            op      <= '0;
            neg     <= 1'b0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            long_q  <= 1'b0;
            flags_q <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op     <= bus.ALUControl;
                        neg    <= smull_req && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                        mcand  <= a_mag;
                        acc_lo <= b_mag;
                        acc_hi <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count + CW'(1);
                end
                FIX: begin
                    res_lo  <= final_prod[WIDTH-1:0];
                    res_hi  <= (op == MUL_OP) ? '0 : final_prod[2*WIDTH-1:WIDTH];
                    long_q  <= (op != MUL_OP);
                    flags_q <= {n_flag, z_flag};
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.ResultLo = res_lo;
    assign bus.ResultHi = res_hi;
    assign bus.long     = long_q;
    assign bus.MulFlags = flags_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed self-checking bench for mul_seq_unit: latency, products, flags, ignored starts,
// invalid opcodes, mid-run reset and back-to-back operation.
module tb_mul_seq_unit;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_seq_unit_if #(.WIDTH(32)) bus ();

    mul_seq_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns one time unit after the capture edge.
    task automatic applyStimulus(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.ALUControl = code;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the capture edge; done is expected in cycle 34.
    task automatic waitDone(input string tag, output int cyc, output bit all_busy);
        cyc      = 1;
        all_busy = 1'b1;
        while (!bus.done && cyc < 100) begin
            if (!bus.busy) all_busy = 1'b0;
            tick();
            cyc++;
        end
        checkOutput({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    endtask

    task automatic runAndCheck(input string tag, input logic [2:0] code, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp_prod,
                               input logic [1:0] exp_flags, input logic exp_long);
        int cyc;
        bit all_busy;
        applyStimulus(code, a, b);
        waitDone(tag, cyc, all_busy);
        checkOutput({tag, "_latency"}, 64'(cyc), 64'd34);
        checkOutput({tag, "_busy_run"}, 64'(all_busy), 64'd1);
        checkOutput({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        checkOutput({tag, "_product"}, {bus.ResultHi, bus.ResultLo}, exp_prod);
        checkOutput({tag, "_flags"}, 64'(bus.MulFlags), 64'(exp_flags));
        checkOutput({tag, "_long"}, 64'(bus.long), 64'(exp_long));
        tick();
        checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        checkOutput({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int  cyc;
        int  n;
        bit  any_busy;
        bit  any_done;

        $display("[TB] starting mul_seq_unit bench");
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.ALUControl = 3'b000;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        tick();
        tick();
        reset = 1'b1;

        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_result", {bus.ResultHi, bus.ResultLo}, 64'd0);
        checkOutput("reset_long", 64'(bus.long), 64'd0);
        checkOutput("reset_flags", 64'(bus.MulFlags), 64'd0);

        runAndCheck("mul_7x6", MUL_OP, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 2'b00, 1'b0);
        runAndCheck("umull_max", UMULL_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2'b10, 1'b1);
        runAndCheck("smull_m3x5", SMULL_OP, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2'b10, 1'b1);
        runAndCheck("smull_minxmin", SMULL_OP, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2'b00, 1'b1);
        runAndCheck("mul_zero_lo", MUL_OP, 32'h0001_0000, 32'h0001_0000, 64'h0, 2'b01, 1'b0);
        runAndCheck("smull_5xm7", SMULL_OP, 32'd5, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD, 2'b10, 1'b1);

        // start while busy (mid-run and in DONE) must be ignored and not queued
        applyStimulus(MUL_OP, 32'd100, 32'd3);
        cyc = 1;
        while (!bus.done && cyc < 100) begin
            if (cyc == 5) begin
                bus.start      = 1'b1;
                bus.ALUControl = UMULL_OP;
                bus.SrcA       = 32'd2;
                bus.SrcB       = 32'd2;
            end else if (cyc == 6) begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        checkOutput("ignore_done_seen", 64'(bus.done), 64'd1);
        checkOutput("ignore_latency", 64'(cyc), 64'd34);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("ignore_product", {bus.ResultHi, bus.ResultLo}, 64'd300);
        checkOutput("ignore_long", 64'(bus.long), 64'd0);
        checkOutput("ignore_not_queued", 64'(bus.busy), 64'd0);
        tick();
        checkOutput("ignore_still_idle", 64'(bus.busy), 64'd0);

        // unsupported opcode in IDLE
        bus.ALUControl = 3'b000;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        any_busy  = 1'b0;
        any_done  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy) any_busy = 1'b1;
            if (bus.done) any_done = 1'b1;
            tick();
        end
        checkOutput("badop_busy", 64'(any_busy), 64'd0);
        checkOutput("badop_done", 64'(any_done), 64'd0);
        checkOutput("hold_result", {bus.ResultHi, bus.ResultLo}, 64'd300);

        // reset in the middle of RUN aborts silently
        applyStimulus(UMULL_OP, 32'hFFFF_FFFF, 32'd2);
        for (int i = 1; i < 10; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_result", {bus.ResultHi, bus.ResultLo}, 64'd0);
        checkOutput("abort_long", 64'(bus.long), 64'd0);
        checkOutput("abort_flags", 64'(bus.MulFlags), 64'd0);
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) any_done = 1'b1;
            tick();
        end
        checkOutput("abort_no_done", 64'(any_done), 64'd0);
        runAndCheck("mul_after_abort", MUL_OP, 32'd2, 32'd3, 64'd6, 2'b00, 1'b0);

        // start held high: one capture per IDLE cycle after done, period 35
        bus.ALUControl = MUL_OP;
        bus.SrcA       = 32'd5;
        bus.SrcB       = 32'd5;
        bus.start      = 1'b1;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        checkOutput("b2b_first_done", 64'(bus.done), 64'd1);
        checkOutput("b2b_first_product", {bus.ResultHi, bus.ResultLo}, 64'd25);
        tick();
        n = 1;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        bus.start = 1'b0;
        checkOutput("b2b_period", 64'(n), 64'd35);
        checkOutput("b2b_second_product", {bus.ResultHi, bus.ResultLo}, 64'd25);
        tick();
        checkOutput("b2b_stop", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
